// File: rtl/redmule_tile_tb_pkg.sv
// Shared types for the RedMulE tile bench monitors: mailbox decode kinds,
// mailbox offsets, AW-info FIFO entry and the default AXI request/response.
package redmule_tile_tb_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned CHAN_W_MAX = 8;
    localparam int unsigned LANE_W_MAX = 4;

    localparam logic [31:0] MBOX_ERR_OFF = 32'h0;
    localparam logic [31:0] MBOX_OUT_OFF = 32'h4;
    localparam logic [31:0] MBOX_EOC_OFF = 32'h8;

    typedef enum logic [1:0] {
        NONE,
        STDERR,
        STDOUT,
        EOC
    } mbox_kind_e;

    // One entry per AW handshake, decoded up front so the pairing stage only selects a lane
    typedef struct packed {
        mbox_kind_e              kind;
        logic [CHAN_W_MAX-1:0]   chan;
        logic [LANE_W_MAX-1:0]   lane;
    } aw_info_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } axi_w_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
    } axi_default_req_t;

    typedef struct packed {
        logic aw_ready;
        logic w_ready;
        logic b_valid;
    } axi_default_rsp_t;

endpackage

// File: rtl/redmule_monitor_fifo.sv
// Small type-parametric FIFO with registered full/empty flags; a push on a full
// FIFO is only accepted when a pop happens in the same cycle, otherwise drop_o pulses.
module redmule_monitor_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o,
    output logic drop_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                 mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic [AddrW:0]   count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        drop_o  = push_i && full_o && !do_pop;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AddrW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_o   <= 1'b0;
            empty_o  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            count_q <= count_d;
            full_o  <= (count_d == (AddrW+1)'(Depth));
            empty_o <= (count_d == '0);
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/redmule_axi_print_monitor.sv
// Passive AXI write monitor: pairs each AW with its W burst in order and decodes
// per-channel stdout/stderr/EOC mailbox writes into registered outputs.
module redmule_axi_print_monitor
    import redmule_tile_tb_pkg::*;
#(
    parameter int unsigned NumChannels = 1,
    parameter int unsigned FifoDepth   = 8,
    parameter logic [31:0] MboxBase    = 32'h2FFF_0000,
    parameter logic [31:0] ChanStride  = 32'h10,
    parameter int unsigned DataWidth   = DATA_W,
    localparam int unsigned ChanW      = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  axi_default_req_t       axi_req_i,
    input  axi_default_rsp_t       axi_rsp_i,
    output logic                   char_valid_o,
    output logic [7:0]             char_o,
    output logic [ChanW-1:0]       char_chan_o,
    output logic [31:0]            errors_o,
    output logic [NumChannels-1:0] eoc_o,
    output logic                   eoc_all_o,
    output logic [31:0]            exit_code_o,
    output logic                   overflow_o
);

    localparam int unsigned NumLanes = DataWidth / 32;
    localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;

    logic              aw_hs;
    logic              w_hs;
    aw_info_t          aw_info;
    logic [63:0]       mbox_base;
    logic [63:0]       aw_addr_ext;

    logic              in_burst_q;
    logic [DATA_W-1:0] first_data_q;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;

    aw_info_t          aw_pop_info;
    logic [DATA_W-1:0] w_pop_data;
    logic              aw_empty;
    logic              aw_full;
    logic              aw_drop;
    logic              w_empty;
    logic              w_full;
    logic              w_drop;
    logic              pair;
    logic [31:0]       word;
    logic [32:0]       err_sum;

    assign aw_hs = axi_req_i.aw_valid && axi_rsp_i.aw_ready;
    assign w_hs  = axi_req_i.w_valid && axi_rsp_i.w_ready;

    // Exact-address decode; channels whose base leaves the 32-bit space never match
    always_comb begin
        aw_info.kind = NONE;
        aw_info.chan = '0;
        aw_info.lane = (NumLanes > 1) ? LANE_W_MAX'(axi_req_i.aw.addr[2 +: LaneW]) : '0;
        mbox_base    = '0;
        aw_addr_ext  = {32'h0, axi_req_i.aw.addr};
        for (int unsigned c = 0; c < NumChannels; c++) begin
            mbox_base = 64'(MboxBase) + 64'(c) * 64'(ChanStride);
            if (mbox_base <= 64'hFFFF_FFFF) begin
                if (aw_addr_ext == mbox_base + 64'(MBOX_ERR_OFF)) begin
                    aw_info.kind = STDERR;
                    aw_info.chan = CHAN_W_MAX'(c);
                end else if (aw_addr_ext == mbox_base + 64'(MBOX_OUT_OFF)) begin
                    aw_info.kind = STDOUT;
                    aw_info.chan = CHAN_W_MAX'(c);
                end else if (aw_addr_ext == mbox_base + 64'(MBOX_EOC_OFF)) begin
                    aw_info.kind = EOC;
                    aw_info.chan = CHAN_W_MAX'(c);
                end
            end
        end
    end

    // Only the first beat carries the mailbox value; later beats are counted but ignored
    always_comb begin
        w_push      = w_hs && axi_req_i.w.last;
        w_push_data = in_burst_q ? first_data_q : axi_req_i.w.data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_burst_q   <= 1'b0;
            first_data_q <= '0;
        end else if (w_hs) begin
            if (!in_burst_q && !axi_req_i.w.last) begin
                in_burst_q   <= 1'b1;
                first_data_q <= axi_req_i.w.data;
            end else if (axi_req_i.w.last) begin
                in_burst_q <= 1'b0;
            end
        end
    end

    redmule_monitor_fifo #(
        .T     (aw_info_t),
        .Depth (FifoDepth)
    ) u_aw_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (aw_hs),
        .data_i  (aw_info),
        .pop_i   (pair),
        .data_o  (aw_pop_info),
        .full_o  (aw_full),
        .empty_o (aw_empty),
        .drop_o  (aw_drop)
    );

    redmule_monitor_fifo #(
        .T     (logic [DATA_W-1:0]),
        .Depth (FifoDepth)
    ) u_w_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (pair),
        .data_o  (w_pop_data),
        .full_o  (w_full),
        .empty_o (w_empty),
        .drop_o  (w_drop)
    );

    always_comb begin
        pair    = !aw_empty && !w_empty;
        word    = 32'(w_pop_data >> {aw_pop_info.lane, 5'b0});
        err_sum = {1'b0, errors_o} + {1'b0, word};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            char_valid_o <= 1'b0;
            char_o       <= '0;
            char_chan_o  <= '0;
            errors_o     <= '0;
            eoc_o        <= '0;
            exit_code_o  <= '0;
            overflow_o   <= 1'b0;
        end else begin
            char_valid_o <= 1'b0;
            if (aw_drop || w_drop) begin
                overflow_o <= 1'b1;
            end
            if (pair) begin
                unique case (aw_pop_info.kind)
                    STDOUT: begin
                        if (word[7:0] != 8'h00) begin
                            char_valid_o <= 1'b1;
                            char_o       <= word[7:0];
                            char_chan_o  <= ChanW'(aw_pop_info.chan);
                        end
                    end
                    STDERR: begin
                        errors_o <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
                    end
                    EOC: begin
                        for (int unsigned c = 0; c < NumChannels; c++) begin
                            if (aw_pop_info.chan == CHAN_W_MAX'(c)) begin
                                eoc_o[c] <= 1'b1;
                            end
                        end
                        if (exit_code_o == 32'h0) begin
                            exit_code_o <= word;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign eoc_all_o = &eoc_o;

    logic unused_bits;
    assign unused_bits = ^{axi_req_i.aw.len, axi_req_i.w.strb, axi_req_i.b_ready,
                           axi_rsp_i.b_valid, aw_full, w_full};

endmodule

// File: tb/tb_redmule_axi_print_monitor.sv
// Randomised scoreboard bench for redmule_axi_print_monitor (2 channels, depth-2 FIFOs).
module tb_redmule_axi_print_monitor;
    import redmule_tile_tb_pkg::*;

    localparam int          NCH    = 2;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] MBOX   = 32'h2FFF_0000;
    localparam logic [31:0] STRIDE = 32'h10;
    localparam int          LANES  = DATA_W / 32;

    logic             clk = 1'b0;
    logic             rst_n;
    axi_default_req_t req;
    axi_default_rsp_t rsp;
    logic             char_valid;
    logic [7:0]       char_byte;
    logic [0:0]       char_chan;
    logic [31:0]      errors;
    logic [NCH-1:0]   eoc;
    logic             eoc_all;
    logic [31:0]      exit_code;
    logic             overflow;

    int               total = 0;
    int               bad   = 0;
    int               exp_q[$];
    longint unsigned  model_err;
    logic [NCH-1:0]   model_eoc;
    logic [31:0]      model_exit;
    logic             model_ovf;

    redmule_axi_print_monitor #(
        .NumChannels (NCH),
        .FifoDepth   (DEPTH),
        .MboxBase    (MBOX),
        .ChanStride  (STRIDE),
        .DataWidth   (DATA_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .axi_req_i    (req),
        .axi_rsp_i    (rsp),
        .char_valid_o (char_valid),
        .char_o       (char_byte),
        .char_chan_o  (char_chan),
        .errors_o     (errors),
        .eoc_o        (eoc),
        .eoc_all_o    (eoc_all),
        .exit_code_o  (exit_code),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every decoded character must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n && char_valid) begin
            checkOutput("char_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                checkOutput("char_value", 64'({char_chan, char_byte}), 64'(exp_q.pop_front()));
                $display("[TB] char [%0d] %c", char_chan, char_byte);
            end
        end
    end

    function automatic logic [DATA_W-1:0] randData();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] buildData(input logic [31:0] addr, input logic [31:0] word);
        logic [DATA_W-1:0] d;
        int lane;
        d    = randData();
        lane = int'((addr >> 2) % LANES);
        d[lane*32 +: 32] = word;
        return d;
    endfunction

    // Reference decode: kind 1 = stderr, 2 = stdout, 3 = EOC, 0 = anything else
    function automatic void decodeAddr(input logic [31:0] addr, output int kind, output int chan);
        longint unsigned off;
        kind = 0;
        chan = 0;
        if (addr >= MBOX) begin
            off = longint'(addr) - longint'(MBOX);
            if (off / STRIDE < NCH) begin
                chan = int'(off / STRIDE);
                case (off % STRIDE)
                    0: kind = 1;
                    4: kind = 2;
                    8: kind = 3;
                    default: kind = 0;
                endcase
            end
        end
    endfunction

    function automatic void modelIssue(input logic [31:0] addr, input logic [31:0] word);
        int kind, chan;
        decodeAddr(addr, kind, chan);
        case (kind)
            1: begin
                model_err = model_err + word;
                if (model_err > 64'hFFFF_FFFF) model_err = 64'hFFFF_FFFF;
            end
            2: if (word[7:0] != 8'h00) exp_q.push_back(chan * 256 + int'(word[7:0]));
            3: begin
                model_eoc[chan] = 1'b1;
                if (model_exit == 32'h0) model_exit = word;
            end
            default: ;
        endcase
    endfunction

    task automatic modelReset();
        model_err  = 0;
        model_eoc  = '0;
        model_exit = '0;
        model_ovf  = 1'b0;
        exp_q.delete();
    endtask

    task automatic sendAw(input logic [31:0] addr, input int beats);
        req.aw.addr  = addr;
        req.aw.len   = 8'(beats - 1);
        req.aw_valid = 1'b1;
        rsp.aw_ready = ($urandom_range(0, 3) != 0);
        if (!rsp.aw_ready) begin
            @(negedge clk);
            rsp.aw_ready = 1'b1;
        end
        @(negedge clk);
        req.aw_valid = 1'b0;
    endtask

    task automatic sendW(input logic [DATA_W-1:0] first, input int beats);
        for (int b = 0; b < beats; b++) begin
            req.w.data   = (b == 0) ? first : randData();
            req.w.last   = (b == beats - 1);
            req.w.strb   = '1;
            req.w_valid  = 1'b1;
            rsp.w_ready  = ($urandom_range(0, 3) != 0);
            if (!rsp.w_ready) begin
                @(negedge clk);
                rsp.w_ready = 1'b1;
            end
            @(negedge clk);
            if (b != beats - 1 && $urandom_range(0, 3) == 0) begin
                req.w_valid = 1'b0;
                @(negedge clk);
            end
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
    endtask

    // order: 0 = AW then W, 1 = W then AW after gap cycles, other = concurrent
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] word,
                                 input int beats, input int order, input int gap);
        logic [DATA_W-1:0] d;
        d = buildData(addr, word);
        modelIssue(addr, word);
        case (order)
            0: begin
                sendAw(addr, beats);
                sendW(d, beats);
            end
            1: begin
                sendW(d, beats);
                repeat (gap) @(negedge clk);
                sendAw(addr, beats);
            end
            default: fork
                sendAw(addr, beats);
                sendW(d, beats);
            join
        endcase
    endtask

    task automatic waitDrain();
        repeat (4) @(negedge clk);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, " errors"}, 64'(errors), model_err);
        checkOutput({tag, " eoc"}, 64'(eoc), 64'(model_eoc));
        checkOutput({tag, " eoc_all"}, 64'(eoc_all), 64'(&model_eoc));
        checkOutput({tag, " exit_code"}, 64'(exit_code), 64'(model_exit));
        checkOutput({tag, " overflow"}, 64'(overflow), 64'(model_ovf));
        checkOutput({tag, " chars_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] randAddr();
        int chan;
        chan = $urandom_range(0, NCH - 1);
        case ($urandom_range(0, 9))
            0, 1, 9: return MBOX + chan * STRIDE + 32'h4;
            2:       return MBOX + chan * STRIDE;
            3:       return MBOX + chan * STRIDE + 32'h8;
            4, 5:    return 32'h1000_0000 + 32'($urandom_range(0, 255) * 4);
            6:       return MBOX + chan * STRIDE + 32'hC;
            7:       return MBOX + NCH * STRIDE + 32'($urandom_range(0, 2) * 4);
            default: return MBOX + chan * STRIDE + 32'h5;
        endcase
    endfunction

    function automatic logic [31:0] randWord(input logic [31:0] addr);
        int kind, chan;
        logic [31:0] w;
        decodeAddr(addr, kind, chan);
        w = $urandom;
        case (kind)
            1: w = 32'($urandom_range(0, 1000));
            2: if ($urandom_range(0, 7) == 0) w[7:0] = 8'h00;
            3: if ($urandom_range(0, 1) == 0) w = 32'h0;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] a;
        req   = '0;
        rsp   = '0;
        rst_n = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkState("reset");
        checkOutput("reset char_valid", 64'(char_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed stdout with latency: handshake edge, then output on the following edge
        modelIssue(32'h2FFF_0014, 32'h41);
        req.aw.addr = 32'h2FFF_0014;
        req.aw.len  = 8'd0;
        req.aw_valid = 1'b1;
        rsp.aw_ready = 1'b1;
        req.w.data  = buildData(32'h2FFF_0014, 32'h0000_0041);
        req.w.last  = 1'b1;
        req.w_valid = 1'b1;
        rsp.w_ready = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        checkOutput("lat edge1 char_valid", 64'(char_valid), 64'd0);
        @(negedge clk);
        checkOutput("lat edge2 char_valid", 64'(char_valid), 64'd1);
        checkOutput("lat edge2 char", 64'(char_byte), 64'h41);
        checkOutput("lat edge2 chan", 64'(char_chan), 64'd1);
        @(negedge clk);
        checkOutput("lat edge3 char_valid", 64'(char_valid), 64'd0);

        // Ordering: L2 burst then stdout with W leading AW by 3 cycles
        applyStimulus(32'h1000_0000, 32'h5555_5555, 4, 0, 0);
        applyStimulus(32'h2FFF_0004, 32'h0000_0042, 1, 1, 3);
        waitDrain();
        checkState("ordering");

        applyStimulus(32'h2FFF_0000, 32'd3, 1, 2, 0);
        applyStimulus(32'h2FFF_0000, 32'd2, 2, 0, 0);
        applyStimulus(32'h2FFF_0008, 32'd0, 1, 1, 1);
        applyStimulus(32'h2FFF_0018, 32'd7, 3, 2, 0);
        waitDrain();
        checkState("stderr_eoc");
        checkOutput("stderr_eoc errors5", 64'(errors), 64'd5);
        checkOutput("stderr_eoc exit7", 64'(exit_code), 64'd7);

        applyStimulus(32'h2FFF_0000, 32'hFFFF_FFF0, 1, 2, 0);
        applyStimulus(32'h2FFF_0010, 32'h0000_0020, 1, 0, 0);
        waitDrain();
        checkState("saturation");
        checkOutput("saturation max", 64'(errors), 64'hFFFF_FFFF);

        // Reset after the 2nd of 4 beats of a stdout burst
        sendAw(32'h2FFF_0004, 4);
        req.w.data  = buildData(32'h2FFF_0004, 32'h0000_005A);
        req.w.last  = 1'b0;
        req.w_valid = 1'b1;
        rsp.w_ready = 1'b1;
        @(negedge clk);
        req.w.data = randData();
        @(negedge clk);
        rst_n       = 1'b0;
        req.w_valid = 1'b0;
        modelReset();
        #1;
        checkState("mid_reset");
        checkOutput("mid_reset char_valid", 64'(char_valid), 64'd0);
        checkOutput("mid_reset char", 64'({char_chan, char_byte}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'h2FFF_0014, 32'h0000_0043, 1, 2, 0);
        waitDrain();
        checkState("post_reset");

        for (int n = 0; n < 60; n++) begin
            a = randAddr();
            applyStimulus(a, randWord(a), $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitDrain();
        checkState("random");

        // Overflow: three AWs into a depth-2 FIFO with W held off
        for (int n = 0; n < 3; n++) sendAw(32'h2FFF_0004, 1);
        model_ovf = 1'b1;
        exp_q.push_back(int'("X"));
        exp_q.push_back(int'("Y"));
        @(negedge clk);
        checkOutput("overflow flag", 64'(overflow), 64'd1);
        sendW(buildData(32'h2FFF_0004, 32'h0000_0058), 1);
        sendW(buildData(32'h2FFF_0004, 32'h0000_0059), 2);
        waitDrain();
        checkState("overflow");
        checkOutput("overflow aw_fifo empty", 64'(dut.u_aw_fifo.empty_o), 64'd1);
        checkOutput("overflow w_fifo empty", 64'(dut.u_w_fifo.empty_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
